uart2_report_tx: RTL
====================

// Module: uart2_report_tx
// PURPOSE
//  Transmit-side counterpart to the UART2 receive path. On a send pulse, latches a tag byte and a
//  16-bit unsigned value, converts the value to 5 decimal ASCII digits, and serialises the frame
//  "<tag>=DDDDD\r\n" (9 bytes) as 8N1 on tx. Sits between the sensor/stopwatch cores and the pin.
//  Uses the shared 16x b_tick from baud_tick_gen2 and contains its own bit shifter.
// PARAMETERS
//  OVERSAMPLE  16  b_tick pulses per UART bit period
//  VALUE_W     16  width of value input; must be <= 16 (5 digits cover 0..65535)
// PORTS
//  clk     in   1        system clock; single clock domain
//  rst     in   1        synchronous, active-high reset
//  b_tick  in   1        1-cycle oversample tick, OVERSAMPLE per bit
//  send    in   1        1-cycle request; sampled only while busy=0
//  tag     in   8        first ASCII byte of the frame, latched on accepted send
//  value   in   VALUE_W  unsigned value to print, latched on accepted send
//  tx      out  1        serial line, idle high
//  busy    out  1        high from the cycle after an accepted send until done
//  done    out  1        1-cycle pulse after the stop bit of the final byte (0x0A)
// BEHAVIOUR
//  Reset (clk edge with rst=1): tx=1, busy=0, done=0, FSM=IDLE, counters/latches cleared.
//   rst mid-frame aborts immediately; the partial byte is not completed and there is no done pulse.
//  States: IDLE -> CONV -> LOAD -> START -> DATA -> [PARITY] -> STOP -> LOAD... -> DONE -> IDLE.
//  IDLE: tx=1. send=1 latches tag and value, sets busy the next cycle, and goes to CONV.
//   send while busy=1 is ignored. It is not queued.
//  CONV: repeated subtraction over weights 10000,1000,100,10,1. One compare/subtract per cycle.
//   A digit is done when remainder < weight; the digit is stored as 0x30+count.
//   Leading zeros are kept. Worst case is <= 50 cycles. No b_tick dependence.
//  Byte order: tag, 0x3D '=', d4..d0 (MSD first), 0x0D, 0x0A; 4-bit byte index, 0..8.
//  LOAD: selects the byte for the index and clears the tick and bit counters. Proceeds on the next
//   cycle without waiting for b_tick.
//  Bit timing: every bit (start/data/parity/stop) lasts exactly OVERSAMPLE b_ticks. The bit counter
//   advances on the b_tick that makes the tick count reach OVERSAMPLE-1; the count then wraps to 0.
//  START: tx=0. DATA: tx=shift[0], LSB first, 8 bits. STOP: tx=1 for one bit.
//  After STOP: if index==8, enter DONE (done=1 for one cycle, busy=0 next cycle, then IDLE).
//   Otherwise increment the index and return to LOAD. There is no idle gap beyond the LOAD cycle.
//  b_tick is ignored outside START/DATA/PARITY/STOP. Inputs may change freely after acceptance.
//  tx is registered. Glitch-free transitions happen only at bit boundaries.
//  A send in the same cycle as done=1 is ignored, because busy is still 1.
// CONFIGURATION
//  `define UART2_TX_PARITY_EN : inserts the PARITY state after DATA. tx = even parity
//   (XOR of the 8 data bits) for one bit period. Frame is 8E1, 11 bit periods per byte.
//  Without the macro: there is no PARITY state and the frame is 8N1, 10 bit periods per byte.
// TESTING
//  (b_tick tied high, OVERSAMPLE=16, so bit = 16 clk)
//  T1: tag=0x54 value=1234 send -> bytes 54 3D 30 31 32 33 34 0D 0A on tx;
//      done once; busy low afterwards.
//  T2: value=65535 -> digits 36 35 35 33 35. value=0 -> 30 30 30 30 30.
//  T3: send pulsed again mid-frame with tag=0x48 -> ignored; only the first frame appears, unchanged.
//  T4: rst asserted during DATA of byte 3 -> next cycle tx=1, busy=0, no done;
//      a fresh send then yields a full frame.
//  T5: b_tick every 651 clk (100 MHz, 9600x16) -> start bit low for 16*651 clk, frame = 90 bits.
//  T6 (UART2_TX_PARITY_EN): byte 0x54 -> parity bit 1; byte 0x30 -> parity bit 0;
//      frame = 99 bit periods.

Source files
------------

// File: rtl/uart2_report_tx_if.sv
// Bundle of the report-transmitter signals between the requesting core and
// the transmitter: the send request with its tag/value payload, the shared
// oversample tick, and the serial line with busy/done status.
// fsm_state exposes the transmitter state for debug and checkers.
interface uart2_report_tx_if #(
  parameter int VALUE_W = 16
);
  logic               b_tick;
  logic               send;
  logic [7:0]         tag;
  logic [VALUE_W-1:0] value;
  logic               tx;
  logic               busy;
  logic               done;
  logic [3:0]         fsm_state;

  // Requesting side: drives the request and tick, observes line and status.
  modport master (
    output b_tick, send, tag, value,
    input  tx, busy, done, fsm_state
  );

  // Transmitter side.
  modport slave (
    input  b_tick, send, tag, value,
    output tx, busy, done, fsm_state
  );
endinterface

// File: rtl/uart2_report_tx.sv
// uart2_report_tx: prints "<tag>=DDDDD\r\n" on a UART line.
// An accepted send latches tag and value, converts value to five decimal
// ASCII digits by repeated subtraction, then shifts out nine bytes LSB first.
// Each bit lasts OVERSAMPLE b_ticks. Define UART2_TX_PARITY_EN to insert an
// even-parity bit after the data bits (8E1); by default the frame is 8N1.
//
// Handshake: send is a one-cycle request sampled only while busy=0; busy
// rises the cycle after acceptance and falls the cycle after the one-cycle
// done pulse, so a send coincident with done is ignored and nothing queues.
module uart2_report_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int VALUE_W    = 16
) (
  input logic              clk,
  input logic              rst,
  uart2_report_tx_if.slave bus
);

  localparam int            TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CONV   = 4'd1,
    S_LOAD   = 4'd2,
    S_START  = 4'd3,
    S_DATA   = 4'd4,
    S_PARITY = 4'd5,
    S_STOP   = 4'd6,
    S_DONE   = 4'd7
  } state_t;

  state_t             state;
  logic [7:0]         tag_q;
  logic [15:0]        rem;
  logic [7:0]         digits [0:4];
  logic [2:0]         widx;
  logic [3:0]         cnt;
  logic [3:0]         byte_idx;
  logic [7:0]         shift;
  logic [TW-1:0]      tick_cnt;
  logic [2:0]         bit_cnt;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic               bit_end;
  logic [7:0]         load_byte;
  logic [VALUE_W-1:0] value_in;
`ifdef UART2_TX_PARITY_EN
  logic [7:0]         cur_byte;
`endif

  assign value_in      = bus.value;
  assign bit_end       = bus.b_tick && (tick_cnt == TICK_LAST);
  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fsm_state = state;

  // Decimal weight for the digit currently being converted (MSD first).
  function automatic logic [15:0] weight(input logic [2:0] i);
    case (i)
      3'd0:    weight = 16'd10000;
      3'd1:    weight = 16'd1000;
      3'd2:    weight = 16'd100;
      3'd3:    weight = 16'd10;
      default: weight = 16'd1;
    endcase
  endfunction

  // Byte of the frame selected by the byte index.
  always_comb begin
    load_byte = 8'h0A;
    case (byte_idx)
      4'd0:    load_byte = tag_q;
      4'd1:    load_byte = 8'h3D;
      4'd2:    load_byte = digits[0];
      4'd3:    load_byte = digits[1];
      4'd4:    load_byte = digits[2];
      4'd5:    load_byte = digits[3];
      4'd6:    load_byte = digits[4];
      4'd7:    load_byte = 8'h0D;
      default: load_byte = 8'h0A;
    endcase
  end

  // Control FSM: conversion, byte sequencing, bit timing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tag_q    <= 8'h00;
      rem      <= 16'h0000;
      for (int i = 0; i < 5; i++) digits[i] <= 8'h00;
      widx     <= 3'd0;
      cnt      <= 4'd0;
      byte_idx <= 4'd0;
      shift    <= 8'h00;
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART2_TX_PARITY_EN
      cur_byte <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (bus.send) begin
            tag_q  <= bus.tag;
            rem    <= 16'(value_in);
            widx   <= 3'd0;
            cnt    <= 4'd0;
            busy_q <= 1'b1;
            state  <= S_CONV;
          end
        end

        // One compare/subtract per cycle; a digit closes when the remainder
        // drops below its weight. Leading zeros are kept.
        S_CONV: begin
          if (rem >= weight(widx)) begin
            rem <= rem - weight(widx);
            cnt <= cnt + 4'd1;
          end else begin
            digits[widx] <= 8'h30 + {4'h0, cnt};
            cnt          <= 4'd0;
            if (widx == 3'd4) begin
              widx     <= 3'd0;
              byte_idx <= 4'd0;
              state    <= S_LOAD;
            end else begin
              widx <= widx + 3'd1;
            end
          end
        end

        // Single-cycle byte fetch; the start bit is driven from the next cycle.
        S_LOAD: begin
          shift    <= load_byte;
`ifdef UART2_TX_PARITY_EN
          cur_byte <= load_byte;
`endif
          tick_cnt <= '0;
          bit_cnt  <= 3'd0;
          tx_q     <= 1'b0;
          state    <= S_START;
        end

        S_START: begin
          if (bus.b_tick) tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
          if (bit_end) begin
            tx_q  <= shift[0];
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (bus.b_tick) tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART2_TX_PARITY_EN
              tx_q  <= ^cur_byte;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx_q    <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        // Only reachable when the parity bit is enabled.
        S_PARITY: begin
          if (bus.b_tick) tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= S_STOP;
          end
        end

        S_STOP: begin
          if (bus.b_tick) tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
          if (bit_end) begin
            if (byte_idx == 4'd8) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= S_LOAD;
            end
          end
        end

        // done is high this cycle with busy still set; busy drops next cycle.
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
